// File: rtl/synth_pkg.sv
// Shared definitions for the voice scheduler: FSM encoding, wavetable bus
// widths and the 16-bit saturation helper.
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACCUM,
        ST_DONE
    } sched_state_t;

    localparam int WT_PHASE_W  = 10;
    localparam int WT_SAMPLE_W = 16;
    localparam int WAVE_SEL_W  = 4;
    localparam int VOICE_IDX_W = 8;

    function automatic logic signed [WT_SAMPLE_W-1:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7fff;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/voice_regfile.sv
// Per-voice synthesis state (increment, waveform, gate, phase) with one config
// write port, one phase-advance port and one read port.
module voice_regfile
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 24,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_cfg_we,
    input  logic [VOICE_IDX_W-1:0] i_cfg_voice,
    input  logic [PHASE_W-1:0]     i_cfg_inc,
    input  logic [WAVE_SEL_W-1:0]  i_cfg_wave,
    input  logic                   i_cfg_gate,
    input  logic                   i_upd_en,
    input  logic [IDX_W-1:0]       i_upd_voice,
    input  logic [IDX_W-1:0]       i_rd_voice,
    output logic [WT_PHASE_W-1:0]  o_rd_phase_top,
    output logic [WAVE_SEL_W-1:0]  o_rd_wave,
    output logic                   o_rd_gate
);

    logic [PHASE_W-1:0]    r_inc   [NUM_VOICES];
    logic [WAVE_SEL_W-1:0] r_wave  [NUM_VOICES];
    logic                  r_gate  [NUM_VOICES];
    logic [PHASE_W-1:0]    r_phase [NUM_VOICES];

    logic             w_cfg_hit;
    logic [IDX_W-1:0] w_cfg_idx;
    logic             w_upd_blocked;

    assign w_cfg_hit     = i_cfg_we && (int'(i_cfg_voice) < NUM_VOICES);
    assign w_cfg_idx     = i_cfg_voice[IDX_W-1:0];
    assign w_upd_blocked = w_cfg_hit && (w_cfg_idx == i_upd_voice);

    // A config write to the voice being advanced overrides the phase step.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_inc[i]   <= '0;
                r_wave[i]  <= '0;
                r_gate[i]  <= 1'b0;
                r_phase[i] <= '0;
            end
        end else begin
            if (i_upd_en && !w_upd_blocked) begin
                r_phase[i_upd_voice] <= r_phase[i_upd_voice] + r_inc[i_upd_voice];
            end
            if (w_cfg_hit) begin
                r_inc[w_cfg_idx]  <= i_cfg_inc;
                r_wave[w_cfg_idx] <= i_cfg_wave;
                r_gate[w_cfg_idx] <= i_cfg_gate;
                if (!i_cfg_gate) begin
                    r_phase[w_cfg_idx] <= '0;
                end
            end
        end
    end

    assign o_rd_phase_top = r_phase[i_rd_voice][PHASE_W-1 -: WT_PHASE_W];
    assign o_rd_wave      = r_wave[i_rd_voice];
    assign o_rd_gate      = r_gate[i_rd_voice];

endmodule

// File: rtl/voice_scheduler.sv
// Sweeps all voices through the shared wavetable once per sample tick and
// produces one saturated mix sample per sweep.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int PHASE_W    = 24,
    parameter int WT_LATENCY = 2,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [VOICE_IDX_W-1:0]        cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_inc,
    input  logic [WAVE_SEL_W-1:0]         cfg_wave,
    input  logic                          cfg_gate,
    output logic [WT_PHASE_W-1:0]         wt_phase,
    output logic [WAVE_SEL_W-1:0]         wt_wave_select,
    output logic [VOICE_IDX_W-1:0]        wt_voice_index,
    input  logic signed [WT_SAMPLE_W-1:0] wt_sample,
    output logic signed [WT_SAMPLE_W-1:0] mix_sample,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = WT_SAMPLE_W + $clog2(NUM_VOICES) + 1;

    sched_state_t r_state;
    sched_state_t w_next;

    logic [VOICE_IDX_W-1:0]        r_v;
    logic [7:0]                    r_wait;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [WT_SAMPLE_W-1:0] r_mix;
    logic                          r_overrun;
    logic [WT_PHASE_W-1:0]         r_wt_phase;
    logic [WAVE_SEL_W-1:0]         r_wt_wave;

    logic [WT_PHASE_W-1:0]   w_rd_phase;
    logic [WAVE_SEL_W-1:0]   w_rd_wave;
    logic                    w_rd_gate;
    logic                    w_last;
    logic                    w_upd_en;
    logic signed [ACC_W-1:0] w_sample_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [31:0]      w_mix_wide;

    voice_regfile #(
        .NUM_VOICES (NUM_VOICES),
        .PHASE_W    (PHASE_W),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk            (clk),
        .reset          (reset),
        .i_cfg_we       (cfg_we),
        .i_cfg_voice    (cfg_voice),
        .i_cfg_inc      (cfg_inc),
        .i_cfg_wave     (cfg_wave),
        .i_cfg_gate     (cfg_gate),
        .i_upd_en       (w_upd_en),
        .i_upd_voice    (r_v[IDX_W-1:0]),
        .i_rd_voice     (r_v[IDX_W-1:0]),
        .o_rd_phase_top (w_rd_phase),
        .o_rd_wave      (w_rd_wave),
        .o_rd_gate      (w_rd_gate)
    );

    assign w_last       = (r_v == VOICE_IDX_W'(NUM_VOICES - 1));
    assign w_upd_en     = (r_state == ST_ACCUM) && w_rd_gate;
    assign w_sample_ext = {{(ACC_W - WT_SAMPLE_W){wt_sample[WT_SAMPLE_W-1]}}, wt_sample};
    assign w_acc_next   = w_rd_gate ? (r_acc + w_sample_ext) : r_acc;
    assign w_shifted    = w_acc_next >>> MIX_SHIFT;
    assign w_mix_wide   = $signed({{(32 - ACC_W){w_shifted[ACC_W-1]}}, w_shifted});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (sample_tick) w_next = ST_ISSUE;
            ST_ISSUE: w_next = (WT_LATENCY == 0) ? ST_ACCUM : ST_WAIT;
            ST_WAIT:  if (r_wait == 8'(WT_LATENCY - 1)) w_next = ST_ACCUM;
            ST_ACCUM: w_next = w_last ? ST_DONE : ST_ISSUE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The final mix is registered on the last ACCUM edge so that it is
    // already stable during the DONE cycle, when mix_valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v        <= '0;
            r_wait     <= '0;
            r_acc      <= '0;
            r_mix      <= '0;
            r_overrun  <= 1'b0;
            r_wt_phase <= '0;
            r_wt_wave  <= '0;
        end else begin
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        r_acc <= '0;
                        r_v   <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_wait     <= '0;
                    r_wt_phase <= w_rd_phase;
                    r_wt_wave  <= w_rd_wave;
                end
                ST_WAIT: begin
                    r_wait <= r_wait + 8'd1;
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_mix <= sat16(w_mix_wide);
                    end else begin
                        r_v <= r_v + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The wavetable sees live regfile values in ISSUE and a frozen copy after.
    always_comb begin
        wt_phase       = '0;
        wt_wave_select = '0;
        wt_voice_index = '0;
        case (r_state)
            ST_ISSUE: begin
                wt_phase       = w_rd_phase;
                wt_wave_select = w_rd_wave;
                wt_voice_index = r_v;
            end
            ST_WAIT, ST_ACCUM: begin
                wt_phase       = r_wt_phase;
                wt_wave_select = r_wt_wave;
                wt_voice_index = r_v;
            end
            default: begin
            end
        endcase
        busy       = (r_state != ST_IDLE);
        mix_valid  = (r_state == ST_DONE);
        mix_sample = r_mix;
        overrun    = r_overrun;
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a constant-output stub wavetable.
module tb_voice_scheduler;

    localparam int SWEEP_LAT = 16 * (2 + 2) + 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_tick;
    logic               cfg_we;
    logic [7:0]         cfg_voice;
    logic [23:0]        cfg_inc;
    logic [3:0]         cfg_wave;
    logic               cfg_gate;
    logic [9:0]         wt_phase;
    logic [3:0]         wt_wave_select;
    logic [7:0]         wt_voice_index;
    logic signed [15:0] stubSample;
    logic signed [15:0] mix_sample;
    logic               mix_valid;
    logic               busy;
    logic               overrun;

    int passCount  = 0;
    int checkCount = 0;
    int seenPhase [256];
    int seenWave  [256];

    always #5 clk = ~clk;

    voice_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .cfg_we         (cfg_we),
        .cfg_voice      (cfg_voice),
        .cfg_inc        (cfg_inc),
        .cfg_wave       (cfg_wave),
        .cfg_gate       (cfg_gate),
        .wt_phase       (wt_phase),
        .wt_wave_select (wt_wave_select),
        .wt_voice_index (wt_voice_index),
        .wt_sample      (stubSample),
        .mix_sample     (mix_sample),
        .mix_valid      (mix_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic writeVoice(input logic [7:0] v, input logic [23:0] inc,
                              input logic [3:0] wave, input logic gate);
        @(negedge clk);
        cfg_we = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_wave = wave; cfg_gate = gate;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One sweep: tick at cycle 0, optional config write and second tick at given cycles.
    task automatic runSweep(input int injCycle, input logic [7:0] injVoice,
                            input logic [23:0] injInc, input logic [3:0] injWave,
                            input logic injGate, input int tick2Cycle,
                            output int latency, output logic signed [15:0] mixOut);
        latency = -1;
        mixOut  = 16'sh5a5a;
        for (int i = 0; i < 256; i++) begin
            seenPhase[i] = -1;
            seenWave[i]  = -1;
        end
        @(negedge clk);
        sample_tick = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            sample_tick = (c == tick2Cycle);
            if (c == injCycle) begin
                cfg_we = 1'b1; cfg_voice = injVoice; cfg_inc = injInc;
                cfg_wave = injWave; cfg_gate = injGate;
            end else begin
                cfg_we = 1'b0;
            end
            if (busy && !mix_valid) begin
                seenPhase[wt_voice_index] = int'(wt_phase);
                seenWave[wt_voice_index]  = int'(wt_wave_select);
            end
            if (mix_valid) begin
                latency = c;
                mixOut  = mix_sample;
                break;
            end
        end
        @(negedge clk);
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
        cfg_inc = '0; cfg_wave = '0; cfg_gate = 1'b0; stubSample = '0;
        repeat (3) @(negedge clk);
        checkCount++;
        if ({busy, mix_valid, overrun} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {busy, mix_valid, overrun});
        else passCount++;
        checkCount++;
        if ({wt_phase, wt_wave_select, wt_voice_index} !== 22'd0) $display("[TB] FAIL reset_wt: got %h expected 0", {wt_phase, wt_wave_select, wt_voice_index});
        else passCount++;
        checkCount++;
        if (mix_sample !== 16'sd0) $display("[TB] FAIL reset_mix: got %0d expected 0", mix_sample);
        else passCount++;
        reset = 1'b0;
    endtask

    task automatic test_silent_sweep();
        int lat;
        logic signed [15:0] mix;
        bit allZero;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (lat !== SWEEP_LAT) $display("[TB] FAIL silent_latency: got %0d expected %0d", lat, SWEEP_LAT);
        else passCount++;
        checkCount++;
        if (mix !== 16'sd0) $display("[TB] FAIL silent_mix: got %0d expected 0", mix);
        else passCount++;
        allZero = 1'b1;
        for (int v = 0; v < 16; v++) if (seenPhase[v] != 0 || seenWave[v] != 0) allZero = 1'b0;
        checkCount++;
        if (!allZero) $display("[TB] FAIL silent_phases: got nonzero/unvisited expected all 0");
        else passCount++;
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL silent_idle: got busy=%b expected 0", busy);
        else passCount++;
    endtask

    task automatic test_single_voice();
        int lat;
        logic signed [15:0] mix;
        writeVoice(8'd0, 24'h040000, 4'd5, 1'b1);
        stubSample = 16'sd1000;
        for (int k = 0; k <= 64; k++) begin
            runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
            checkCount++;
            if (mix !== 16'sd250 || lat !== SWEEP_LAT) $display("[TB] FAIL single_mix_%0d: got %0d (lat %0d) expected 250 (lat %0d)", k, mix, lat, SWEEP_LAT);
            else passCount++;
            checkCount++;
            if (seenPhase[0] !== (16 * k) % 1024) $display("[TB] FAIL single_phase_%0d: got %0d expected %0d", k, seenPhase[0], (16 * k) % 1024);
            else passCount++;
        end
        checkCount++;
        if (seenWave[0] !== 5) $display("[TB] FAIL single_wave: got %0d expected 5", seenWave[0]);
        else passCount++;
    endtask

    task automatic test_saturation();
        int lat;
        logic signed [15:0] mix;
        logic signed [15:0] stubs [4] = '{16'sd32767, -16'sd32768, 16'sd100, -16'sd1};
        logic signed [15:0] exps  [4] = '{16'sd32767, -16'sd32768, 16'sd400, -16'sd4};
        for (int v = 1; v < 16; v++) writeVoice(8'(v), 24'd0, 4'd0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            stubSample = stubs[t];
            runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
            checkCount++;
            if (mix !== exps[t]) $display("[TB] FAIL sat_%0d: got %0d expected %0d", t, mix, exps[t]);
            else passCount++;
        end
    endtask

    task automatic test_overrun();
        int lat;
        logic signed [15:0] mix;
        doReset();
        checkCount++;
        if (overrun !== 1'b0) $display("[TB] FAIL ovr_cleared: got %b expected 0", overrun);
        else passCount++;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, SWEEP_LAT, lat, mix);
        checkCount++;
        if (lat !== SWEEP_LAT || busy !== 1'b0 || overrun !== 1'b1) $display("[TB] FAIL ovr_done_tick: got lat %0d busy %b ovr %b expected lat %0d busy 0 ovr 1", lat, busy, overrun, SWEEP_LAT);
        else passCount++;
        doReset();
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, 10, lat, mix);
        checkCount++;
        if (lat !== SWEEP_LAT || busy !== 1'b0 || overrun !== 1'b1) $display("[TB] FAIL ovr_busy_tick: got lat %0d busy %b ovr %b expected lat %0d busy 0 ovr 1", lat, busy, overrun, SWEEP_LAT);
        else passCount++;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (lat !== SWEEP_LAT || overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got lat %0d ovr %b expected lat %0d ovr 1", lat, overrun, SWEEP_LAT);
        else passCount++;
    endtask

    task automatic test_gate_clear();
        int lat;
        logic signed [15:0] mix;
        doReset();
        writeVoice(8'd3, 24'h100000, 4'd2, 1'b1);
        stubSample = 16'sd1000;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd250 || seenPhase[3] !== 0) $display("[TB] FAIL gc_first: got mix %0d ph %0d expected 250 0", mix, seenPhase[3]);
        else passCount++;
        runSweep(16, 8'd3, 24'h100000, 4'd2, 1'b0, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd250 || seenPhase[3] !== 64) $display("[TB] FAIL gc_accum_write: got mix %0d ph %0d expected 250 64", mix, seenPhase[3]);
        else passCount++;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd0 || seenPhase[3] !== 0) $display("[TB] FAIL gc_after: got mix %0d ph %0d expected 0 0", mix, seenPhase[3]);
        else passCount++;
        writeVoice(8'd20, 24'hFFFFFF, 4'hF, 1'b1);
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd0 || seenWave[4] !== 0) $display("[TB] FAIL gc_voice20: got mix %0d wave4 %0d expected 0 0", mix, seenWave[4]);
        else passCount++;
    endtask

    task automatic test_unvisited_write();
        int lat;
        logic signed [15:0] mix;
        runSweep(2, 8'd10, 24'd0, 4'd7, 1'b1, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd250 || seenWave[10] !== 7) $display("[TB] FAIL uv_ahead: got mix %0d wave %0d expected 250 7", mix, seenWave[10]);
        else passCount++;
        runSweep(8, 8'd0, 24'd0, 4'd0, 1'b1, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd250) $display("[TB] FAIL uv_behind: got %0d expected 250", mix);
        else passCount++;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (mix !== 16'sd500) $display("[TB] FAIL uv_next: got %0d expected 500", mix);
        else passCount++;
    endtask

    task automatic test_reset_mid_sweep();
        int lat;
        logic signed [15:0] mix;
        bit reached = 1'b0;
        bit sawValid = 1'b0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (mix_valid) sawValid = 1'b1;
            if (busy && wt_voice_index == 8'd7) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkCount++;
        if (!reached) $display("[TB] FAIL rst_reach_v7: got no voice 7 expected voice 7 within 100 cycles");
        else passCount++;
        reset = 1'b1;
        @(negedge clk);
        checkCount++;
        if (busy !== 1'b0 || mix_valid !== 1'b0) $display("[TB] FAIL rst_busy: got busy %b valid %b expected 0 0", busy, mix_valid);
        else passCount++;
        reset = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (mix_valid) sawValid = 1'b1;
        end
        checkCount++;
        if (sawValid) $display("[TB] FAIL rst_no_valid: got mix_valid pulse expected none");
        else passCount++;
        runSweep(-1, 8'd0, 24'd0, 4'd0, 1'b0, -1, lat, mix);
        checkCount++;
        if (lat !== SWEEP_LAT || mix !== 16'sd0 || seenPhase[0] !== 0 || overrun !== 1'b0) $display("[TB] FAIL rst_next_sweep: got lat %0d mix %0d ph0 %0d ovr %b expected %0d 0 0 0", lat, mix, seenPhase[0], overrun, SWEEP_LAT);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_silent_sweep();
        test_single_voice();
        test_saturation();
        test_overrun();
        test_gate_clear();
        test_unvisited_write();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
